// File: rtl/pc_sequencer.sv
// Next-PC sequencer with sequential, relative, absolute, call and return modes,
// backed by a circular return-address stack that overwrites its oldest entry when full.
module pc_sequencer #(
    parameter int               WIDTH        = 64,
    parameter int               RAS_DEPTH    = 4,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load,
    input  logic [2:0]                 PS,
    input  logic [WIDTH-1:0]           X,
    output logic [WIDTH-1:0]           PC_out,
    output logic [WIDTH-1:0]           PC4,
    output logic [WIDTH-1:0]           Adder_Out,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ras_ovf,
    output logic                       ras_unf
);

    localparam int               PTR_W    = $clog2(RAS_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(INC);

    typedef enum logic [2:0] {
        PS_HOLD  = 3'b000,
        PS_SEQ   = 3'b001,
        PS_REL   = 3'b010,
        PS_ABS   = 3'b011,
        PS_CALL  = 3'b100,
        PS_RET   = 3'b101,
        PS_ICALL = 3'b110,
        PS_RSVD  = 3'b111
    } ps_e;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_pc4;
    logic [WIDTH-1:0] w_adder;
    logic [WIDTH-1:0] w_next_pc;
    logic [PTR_W-1:0] w_top_inc;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;

    assign w_pc4     = r_pc + STEP;
    assign w_adder   = r_pc + X;
    assign w_top_inc = r_top + PTR_W'(1);
    assign w_empty   = (r_count == '0);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_pc = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        case (ps_e'(PS))
            PS_SEQ:   w_next_pc = w_pc4;
            PS_REL:   w_next_pc = w_adder;
            PS_ABS:   w_next_pc = X;
            PS_CALL: begin
                w_next_pc = w_adder;
                w_push    = 1'b1;
            end
            PS_RET: begin
                w_next_pc = w_empty ? w_pc4 : r_stack[r_top];
                w_pop     = 1'b1;
            end
            PS_ICALL: begin
                w_next_pc = X;
                w_push    = 1'b1;
            end
            default:  w_next_pc = r_pc;
        endcase
    end

    // NOTE: the stack storage has no reset; r_count gates every read, so stale entries are never visible.
    always_ff @(posedge clock) begin
        if (!reset && load && w_push) begin
            r_stack[w_top_inc] <= w_pc4;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= RESET_VECTOR;
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_unf <= 1'b0;
            if (load) begin
                r_pc <= w_next_pc;
                if (w_push) begin
                    // A push while full lands on the oldest slot, which is the one just past the top.
                    r_top <= w_top_inc;
                    if (r_count == FULL_CNT) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end else if (w_pop) begin
                    if (w_empty) begin
                        r_unf <= 1'b1;
                    end else begin
                        r_top   <= r_top - PTR_W'(1);
                        r_count <= r_count - CNT_W'(1);
                    end
                end
            end
        end
    end

    assign PC_out    = r_pc;
    assign PC4       = w_pc4;
    assign Adder_Out = w_adder;
    assign ras_count = r_count;
    assign ras_empty = w_empty;
    assign ras_full  = (r_count == FULL_CNT);
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: two sequencer configurations driven with the same directed and random
// stimulus; a queue-based reference model predicts each cycle and a monitor compares.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load  = 1'b0;
    logic [2:0]  ps    = 3'b000;
    logic [63:0] x_a   = '0;
    logic [31:0] x_b   = '0;

    always #5 clock = ~clock;

    logic [63:0] a_pc, a_pc4, a_add;
    logic [2:0]  a_cnt;
    logic        a_empty, a_full, a_ovf, a_unf;
    logic [31:0] b_pc, b_pc4, b_add;
    logic [1:0]  b_cnt;
    logic        b_empty, b_full, b_ovf, b_unf;

    pc_sequencer #(.WIDTH(64), .RAS_DEPTH(4), .INC(4), .RESET_VECTOR(64'h0)) dut_a (
        .clock(clock), .reset(reset), .load(load), .PS(ps), .X(x_a),
        .PC_out(a_pc), .PC4(a_pc4), .Adder_Out(a_add), .ras_count(a_cnt),
        .ras_empty(a_empty), .ras_full(a_full), .ras_ovf(a_ovf), .ras_unf(a_unf)
    );

    pc_sequencer #(.WIDTH(32), .RAS_DEPTH(2), .INC(4), .RESET_VECTOR(32'h1000)) dut_b (
        .clock(clock), .reset(reset), .load(load), .PS(ps), .X(x_b),
        .PC_out(b_pc), .PC4(b_pc4), .Adder_Out(b_add), .ras_count(b_cnt),
        .ras_empty(b_empty), .ras_full(b_full), .ras_ovf(b_ovf), .ras_unf(b_unf)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the stack is a plain array with the newest entry at index 0.
    int          depth_p [2];
    logic [63:0] mask_p  [2];
    logic [63:0] rv_p    [2];
    logic [63:0] m_pc    [2];
    logic [63:0] m_stk   [2][4];
    int          m_cnt   [2];
    bit          m_ovf   [2];
    bit          m_unf   [2];

    typedef struct {
        int          id;
        logic [63:0] pc;
        logic [63:0] pc4;
        logic [63:0] add;
        int          cnt;
        bit          ovf;
        bit          unf;
    } exp_t;

    exp_t exp_q[$];

    task automatic model_push(int id, logic [63:0] v);
        if (m_cnt[id] == depth_p[id]) m_ovf[id] = 1'b1;
        else                          m_cnt[id]++;
        for (int i = 3; i > 0; i--) m_stk[id][i] = m_stk[id][i-1];
        m_stk[id][0] = v;
    endtask

    task automatic model_step(int id, bit rst, bit ld, logic [2:0] p, logic [63:0] x);
        logic [63:0] xm, seq;
        exp_t        e;
        xm  = x & mask_p[id];
        seq = (m_pc[id] + 64'd4) & mask_p[id];
        m_unf[id] = 1'b0;
        if (rst) begin
            m_pc[id]  = rv_p[id];
            m_cnt[id] = 0;
            m_ovf[id] = 1'b0;
        end else if (ld) begin
            case (p)
                3'd1: m_pc[id] = seq;
                3'd2: m_pc[id] = (m_pc[id] + xm) & mask_p[id];
                3'd3: m_pc[id] = xm;
                3'd4: begin
                    model_push(id, seq);
                    m_pc[id] = (m_pc[id] + xm) & mask_p[id];
                end
                3'd5: begin
                    if (m_cnt[id] > 0) begin
                        m_pc[id] = m_stk[id][0];
                        for (int i = 0; i < 3; i++) m_stk[id][i] = m_stk[id][i+1];
                        m_cnt[id]--;
                    end else begin
                        m_pc[id]  = seq;
                        m_unf[id] = 1'b1;
                    end
                end
                3'd6: begin
                    model_push(id, seq);
                    m_pc[id] = xm;
                end
                default: m_pc[id] = m_pc[id];
            endcase
        end
        e.id  = id;
        e.pc  = m_pc[id];
        e.pc4 = (m_pc[id] + 64'd4) & mask_p[id];
        e.add = (m_pc[id] + xm) & mask_p[id];
        e.cnt = m_cnt[id];
        e.ovf = m_ovf[id];
        e.unf = m_unf[id];
        exp_q.push_back(e);
    endtask

    task automatic apply(bit rst, bit ld, logic [2:0] p, logic [63:0] x);
        @(negedge clock);
        reset = rst;
        load  = ld;
        ps    = p;
        x_a   = x;
        x_b   = x[31:0];
        model_step(0, rst, ld, p, x);
        model_step(1, rst, ld, p, x);
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    // Monitor: every edge presents a new output set; compare it to the queued prediction.
    initial begin
        exp_t        e;
        logic [63:0] pc, pc4, add, cnt;
        bit          emp, ful, ovf, unf;
        string       tag;
        forever begin
            @(posedge clock);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.id == 0) begin
                    pc = a_pc; pc4 = a_pc4; add = a_add; cnt = 64'(a_cnt);
                    emp = a_empty; ful = a_full; ovf = a_ovf; unf = a_unf;
                end else begin
                    pc = 64'(b_pc); pc4 = 64'(b_pc4); add = 64'(b_add); cnt = 64'(b_cnt);
                    emp = b_empty; ful = b_full; ovf = b_ovf; unf = b_unf;
                end
                tag = (e.id == 0) ? "a" : "b";
                check({tag, ".PC_out"},    pc,  e.pc);
                check({tag, ".PC4"},       pc4, e.pc4);
                check({tag, ".Adder_Out"}, add, e.add);
                check({tag, ".ras_count"}, cnt, 64'(e.cnt));
                check({tag, ".ras_empty"}, 64'(emp), 64'(e.cnt == 0));
                check({tag, ".ras_full"},  64'(ful), 64'(e.cnt == depth_p[e.id]));
                check({tag, ".ras_ovf"},   64'(ovf), 64'(e.ovf));
                check({tag, ".ras_unf"},   64'(unf), 64'(e.unf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] x;
        logic [63:0] ret_exp [4];
        depth_p = '{4, 2};
        mask_p  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        rv_p    = '{64'h0, 64'h1000};
        m_pc    = '{64'h0, 64'h0};
        m_cnt   = '{0, 0};
        m_ovf   = '{1'b0, 1'b0};
        m_unf   = '{1'b0, 1'b0};

        apply(1, 0, 3'd0, 64'h0);
        apply(1, 1, 3'd5, 64'h0);
        settle();
        check("reset a.PC_out", a_pc, 64'h0);
        check("reset b.PC_out", 64'(b_pc), 64'h1000);

        // Sequential fetch
        repeat (3) apply(0, 1, 3'd1, 64'h0);
        settle();
        check("fetch a.PC_out", a_pc, 64'd12);
        check("fetch a.PC4", a_pc4, 64'd16);
        check("fetch b.PC_out", 64'(b_pc), 64'h100C);
        check("fetch b.PC4", 64'(b_pc4), 64'h1010);

        // Relative and absolute branch, then load low
        apply(0, 1, 3'd2, -64'sd8);
        settle();
        check("rel a.PC_out", a_pc, 64'd4);
        apply(0, 1, 3'd3, 64'h100);
        apply(0, 0, 3'd1, 64'h55);
        apply(0, 0, 3'd5, 64'h0);
        settle();
        check("hold a.PC_out", a_pc, 64'h100);

        // Call and return
        apply(0, 1, 3'd4, 64'h40);
        settle();
        check("call a.PC_out", a_pc, 64'h140);
        check("call a.ras_count", 64'(a_cnt), 64'd1);
        check("call b.PC_out", 64'(b_pc), 64'h140);
        apply(0, 1, 3'd5, 64'h0);
        settle();
        check("ret a.PC_out", a_pc, 64'h104);
        check("ret a.ras_count", 64'(a_cnt), 64'd0);

        // Overflow: five calls into a four-deep stack, then drain it
        repeat (5) apply(0, 1, 3'd4, 64'h40);
        settle();
        check("ovf a.ras_full", 64'(a_full), 64'd1);
        check("ovf a.ras_ovf", 64'(a_ovf), 64'd1);
        ret_exp = '{64'h208, 64'h1C8, 64'h188, 64'h148};
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 3'd5, 64'h0);
            settle();
            check($sformatf("lifo[%0d] a.PC_out", i), a_pc, ret_exp[i]);
        end
        apply(0, 1, 3'd5, 64'h0);
        settle();
        check("unf a.ras_unf", 64'(a_unf), 64'd1);
        check("unf a.PC_out", a_pc, 64'h14C);
        apply(0, 0, 3'd5, 64'h0);
        settle();
        check("unf pulse end a.ras_unf", 64'(a_unf), 64'd0);

        // Wrap past all-ones, then reset with live stack entries
        apply(0, 1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC);
        apply(0, 1, 3'd1, 64'h0);
        settle();
        check("wrap a.PC_out", a_pc, 64'h0);
        check("wrap b.PC_out", 64'(b_pc), 64'h0);
        apply(0, 1, 3'd4, 64'h40);
        apply(0, 1, 3'd6, 64'h80);
        settle();
        check("pre-reset a.ras_count", 64'(a_cnt), 64'd2);
        apply(1, 1, 3'd4, 64'h40);
        settle();
        check("mid-reset a.PC_out", a_pc, 64'h0);
        check("mid-reset a.ras_count", 64'(a_cnt), 64'd0);
        check("mid-reset a.ras_ovf", 64'(a_ovf), 64'd0);
        apply(0, 1, 3'd5, 64'h0);
        settle();
        check("post-reset a.ras_unf", 64'(a_unf), 64'd1);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 1) x = {$urandom(), $urandom()};
            else                           x = 64'($urandom_range(0, 511)) - 64'd256;
            apply($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
                  3'($urandom_range(0, 7)), x);
        end

        apply(0, 0, 3'd0, 64'h0);
        repeat (2) settle();
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
